// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch with a one-entry decode buffer,
// stale-response dropping on redirect and sticky fault capture.
module instruction_fetch #(
    parameter logic [31:0] START_ADDRESS       = 32'h0100_0000,
    parameter logic [31:0] UPPER_ADDRESS_LIMIT = 32'h0100_0FFC,
    parameter int unsigned RESP_TIMEOUT        = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic        halt_i,
    input  logic        flush_i,
    output logic        pc_advance_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        fetch_fault_o,
    output logic [1:0]  fault_cause_o
);
    localparam int CW = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   ipc_q, ipc_d;
    logic          valid_q, valid_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          bad_addr, timeout, issue;

    assign bad_addr = (pc_i[1:0] != 2'b00) || (pc_i < START_ADDRESS) || (pc_i > UPPER_ADDRESS_LIMIT);
    assign timeout  = (cnt_q + CW'(1)) == CW'(RESP_TIMEOUT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= START_ADDRESS;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: issue = !halt_i && !flush_i;
            REQ: begin
                if (imem_ack_i) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (drop_q || flush_i) begin
                        state_d = IDLE;
                    end else if (imem_err_i) begin
                        state_d = FAULT;
                        cause_d = 2'b01;
                    end else begin
                        instr_d = imem_rdata_i;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    drop_d = drop_q || flush_i;
                    cnt_d  = cnt_q + CW'(1);
                    if (timeout) begin
                        state_d = FAULT;
                        cause_d = 2'b10;
                        req_d   = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (flush_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (instr_ready_i) begin
                    valid_d = 1'b0;
                    state_d = halt_i ? IDLE : state_q;
                    issue   = !halt_i;
                end
            end
            default: ;
        endcase
        // Shared issue path: from IDLE and back-to-back from a HOLD handshake
        if (issue) begin
            if (bad_addr) begin
                state_d = FAULT;
                cause_d = 2'b11;
            end else begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = pc_i;
                cnt_d   = '0;
                drop_d  = 1'b0;
            end
        end
    end

    always_comb begin
        imem_req_o    = req_q;
        imem_addr_o   = addr_q;
        instr_o       = instr_q;
        instr_pc_o    = ipc_q;
        instr_valid_o = valid_q;
        fetch_fault_o = state_q == FAULT;
        fault_cause_o = cause_q;
        pc_advance_o  = (state_q == REQ) && imem_ack_i && !drop_q && !flush_i && !imem_err_i;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage sitting directly downstream of the program counter. Takes the current PC, issues a single-outstanding read on the instruction-memory port with a req/ack handshake, and holds the returned word in a one-entry output buffer for decode under a valid/ready handshake. Drives `pcAdvance` back to the PC stage, discards responses made stale by a branch/jump redirect, and latches sticky fault status on bad addresses, bus errors and response timeouts.

## Interface
- `START_ADDRESS`, 32'h01000000: lowest legal fetch address.
- `UPPER_ADDRESS_LIMIT`, 32'h01000FFC: highest legal fetch address.
- `RESP_TIMEOUT`, 16: REQ cycles without `imemAck` before a timeout fault (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `pc` in 32: current PC from the program counter.
- `halt` in 1: PC-stage halt; no new fetch is issued while high.
- `flush` in 1: redirect taken (pcSelect path). Kills the buffered or in-flight fetch.
- `pcAdvance` out 1: one-cycle pulse allowing the PC to step.
- `imemReq` out 1: memory read request.
- `imemAddr` out 32: read address, stable while `imemReq` is high.
- `imemAck` in 1: response valid.
- `imemRdata` in 32: read data, sampled on `imemAck`.
- `imemErr` in 1: bus error, qualified by `imemAck`.
- `instr` out 32: fetched instruction.
- `instrPc` out 32: address of `instr`.
- `instrValid` out 1: output buffer full.
- `instrReady` in 1: decode accepts.
- `fetchFault` out 1: sticky fault flag.
- `faultCause` out 2: fault cause. 01 = bus error, 10 = timeout, 11 = bad address, 00 = none.

## Operation
- State machine: IDLE, REQ, HOLD, FAULT. Reset enters IDLE.
- Output reset values:
  - `imemReq` 0; `imemAddr` START_ADDRESS.
  - `instr` 0; `instrPc` 0; `instrValid` 0.
  - `fetchFault` 0; `faultCause` 00.
  - `pcAdvance` 0.
  - Internal: drop flag 0, timeout counter 0.
- Issue check applies whenever a fetch would be issued:
  - Bad address if `pc[1:0]` != 0, or `pc` < START_ADDRESS, or `pc` > UPPER_ADDRESS_LIMIT.
  - A bad address goes to FAULT with cause 11. No request is made.
- IDLE:
  - `halt`=1 or `flush`=1: stay in IDLE.
  - Otherwise: register `imemAddr`←`pc`, `imemReq`←1, clear the timeout counter, go to REQ.
- REQ:
  - `imemReq` stays high and `imemAddr` stays stable until `imemAck`. A request is never withdrawn.
  - `flush` while in REQ without ack: set the drop flag.
  - Ack with drop flag set, or `flush` in the ack cycle: discard data, no `pcAdvance`, clear the drop flag, go to IDLE.
  - Ack with `imemErr`: go to FAULT, cause 01.
  - Ack, clean: `instr`←`imemRdata`, `instrPc`←`imemAddr`, `instrValid`←1, `imemReq`←0, go to HOLD. `pcAdvance`=1 combinationally in the ack cycle.
  - No ack: counter increments. Counter reaching RESP_TIMEOUT → FAULT, cause 10, `imemReq`←0.
  - Counter width is clog2(RESP_TIMEOUT+1).
- HOLD:
  - `instrValid` stays high and `instr`/`instrPc` stay stable until `instrValid`&&`instrReady`.
  - `flush` has priority: `instrValid`←0, go to IDLE.
  - On handshake with `halt`=0: run the issue check on the current `pc` and issue the next request in the same edge (back-to-back).
  - On handshake with `halt`=1: go to IDLE.
- FAULT:
  - Sticky until `rst`.
  - `imemReq`=0, `instrValid`=0, `pcAdvance`=0, `fetchFault`=1.
  - `faultCause` holds the first cause.
- `pcAdvance` is asserted only for clean, non-dropped acks. This gives exactly one PC step per delivered instruction.

## Timing
- Issue from IDLE:
  - Cycle t: `pc` is sampled.
  - t+1: `imemReq` high.
  - Zero-wait ack at t+1: `pcAdvance` pulses at t+1, `instrValid` is high at t+2.
  - Each wait state adds one cycle.
- Sustained throughput with zero-wait memory and `instrReady`=1: one instruction per 2 cycles.
- The next fetch uses the PC value after the pulse, which has been updated at the pulse edge.
- Simultaneous `flush` and ack: flush wins, data is dropped.
- Simultaneous `flush` and `instrReady` in HOLD: flush wins, no new issue.
- `rst` asserted at any time, including with a request outstanding:
  - All outputs return to their reset values asynchronously.
  - A late ack arriving after `rst` deasserts while in IDLE is ignored.

## Test plan
- Reset release with `pc`=0x01000000, zero-wait memory returning 0x00500093, `instrReady`=1:
  - `imemReq` high cycle 1, `pcAdvance` pulse cycle 1, `instrValid` cycle 2 with `instrPc`=0x01000000.
  - Next request at `imemAddr`=0x01000004.
- Ack delayed 3 cycles, `instrReady` low 2 cycles in HOLD:
  - `imemAddr` is stable for all 4 REQ cycles.
  - `instr`/`instrPc` are stable in HOLD.
  - Exactly one `pcAdvance`.
- `flush` during REQ with ack 2 cycles later:
  - No `instrValid`, no `pcAdvance`.
  - Returns to IDLE, then fetches the redirected `pc`=0x01000100.
- `pc`=0x01000002:
  - `fetchFault`=1, `faultCause`=11, `imemReq` is never asserted.
- Ack with `imemErr`=1 → `faultCause`=01.
- Separate run with no ack for 16 cycles → `faultCause`=10 and `imemReq` drops.
- `rst` low mid-REQ → all outputs at reset values immediately; after release, fetch restarts cleanly.
